// File: rtl/snes_region_ctrl.sv
// Region/mode controller for the SNES multi-region board.
// Short presses of the console reset button become normal console resets.
// A long hold steps through four region modes. The chosen mode is applied
// while the console is held in reset, so mode outputs never change under a
// running console.
module snes_region_ctrl #(
    parameter int CNT_W    = 25,
    parameter int DEB_CYC  = 429545,
    parameter int LONG_CYC = 21477270,
    parameter int STEP_CYC = 21477270,
    parameter int RST_HOLD = 2147727
) (
    input  logic       MCLK_i,
    input  logic       NRST_i,
    input  logic       NRST_BTN_i,
    input  logic [1:0] MODE_DEFAULT_i,
    output logic       NRST_CONSOLE_o,
    output logic       PALMODE_o,
    output logic       EN_REGPATCH_o,
    output logic       DEJITTER_BYPASS_o,
    output logic [1:0] LED_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_END = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD - 1);

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_PRESS   = 3'd2,
        ST_SELECT  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_APPLY   = 3'd5
    } state_t;

    // Next mode in the cycle NTSC -> PAL -> NTSC+patch -> PAL+patch -> NTSC.
    function automatic logic [1:0] mode_inc(input logic [1:0] m);
        return m + 2'd1;
    endfunction

    logic             btn_meta_r;
    logic             btn_sync_r;
    logic             btn_db_r;
    logic [CNT_W-1:0] deb_cnt_r;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [1:0]       mode_r;
    logic [1:0]       mode_s;
    logic [1:0]       pend_r;
    logic [1:0]       pend_s;
    logic [1:0]       pend_step_s;

    logic             nrst_console_r;
    logic             pal_r;
    logic             patch_r;
    logic [1:0]       led_r;

    // Two-flop synchronizer for the asynchronous button; idles released.
    always_ff @(posedge MCLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
        end else begin
            btn_meta_r <= NRST_BTN_i;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debounce: accept a new level only after it has held for DEB_CYC cycles.
    always_ff @(posedge MCLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            deb_cnt_r <= CNT_ZERO;
            btn_db_r  <= 1'b1;
        end else if (btn_sync_r == btn_db_r) begin
            deb_cnt_r <= CNT_ZERO;
        end else if (deb_cnt_r == DEB_END) begin
            deb_cnt_r <= CNT_ZERO;
            btn_db_r  <= btn_sync_r;
        end else begin
            deb_cnt_r <= deb_cnt_r + CNT_ONE;
        end
    end

    // Next-state, shared counter, pending and applied mode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mode_s      = mode_r;
        pend_s      = pend_r;
        pend_step_s = pend_r;
        case (state_r)
            ST_BOOT: begin
                mode_s  = MODE_DEFAULT_i;
                cnt_s   = CNT_ZERO;
                state_s = ST_APPLY;
            end
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (!btn_db_r) begin
                    state_s = ST_PRESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (btn_db_r) begin
                    state_s = ST_RELEASE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == LONG_END) begin
                    state_s = ST_SELECT;
                    pend_s  = mode_inc(mode_r);
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SELECT: begin
                // A step landing on the release cycle still counts.
                if (cnt_r == STEP_END) begin
                    pend_step_s = mode_inc(pend_r);
                    cnt_s       = CNT_ZERO;
                end else begin
                    pend_step_s = pend_r;
                    cnt_s       = cnt_r + CNT_ONE;
                end
                pend_s = pend_step_s;
                if (btn_db_r) begin
                    mode_s  = pend_step_s;
                    state_s = ST_APPLY;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_SELECT;
                end
            end
            ST_RELEASE, ST_APPLY: begin
                if (cnt_r == HOLD_END) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_BOOT;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, counter and mode registers.
    always_ff @(posedge MCLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            state_r <= ST_BOOT;
            cnt_r   <= CNT_ZERO;
            mode_r  <= 2'd0;
            pend_r  <= 2'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            mode_r  <= mode_s;
            pend_r  <= pend_s;
        end
    end

    // Output registers: console reset follows the next state so it drops on
    // the same edge the FSM leaves IDLE; mode outputs lag the applied mode.
    always_ff @(posedge MCLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            nrst_console_r <= 1'b0;
            pal_r          <= 1'b0;
            patch_r        <= 1'b0;
            led_r          <= 2'd0;
        end else begin
            nrst_console_r <= (state_s == ST_IDLE);
            pal_r          <= mode_r[0];
            patch_r        <= mode_r[1];
            led_r          <= (state_r == ST_SELECT) ? pend_r : mode_r;
        end
    end

    assign NRST_CONSOLE_o    = nrst_console_r;
    assign PALMODE_o         = pal_r;
    assign EN_REGPATCH_o     = patch_r;
    assign DEJITTER_BYPASS_o = pal_r;
    assign LED_o             = led_r;

endmodule
